// File: rtl/alu_mod_sequencer_pkg.sv
// Shared ALU opcodes and 2-bit FSM state encodings for the modulo sequencer.
package alu_mod_sequencer_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CMP  = 2'b01;
    localparam logic [1:0] ST_SUB  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/alu_mod_sequencer.sv
// A mod B by repeated SLT/SUB passes through an external ALU; MOD_QUOTIENT_EN adds a quotient port.
// Latency: done 2+2Q edges after the start-sampling edge (1 edge on illegal operands).
// Backpressure: none; start is only accepted in IDLE and ignored while busy or on the done cycle.
module alu_mod_sequencer
    import alu_mod_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res
`ifdef MOD_QUOTIENT_EN
    ,
    output logic [WIDTH-1:0] quotient
`endif
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
`ifdef MOD_QUOTIENT_EN
    logic [WIDTH-1:0] q_q, q_d;
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        rem_d   = rem_q;
        err_d   = err_q;
`ifdef MOD_QUOTIENT_EN
        q_d     = q_q;
`endif
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALU_OP_AND;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r_d   = op_a;
                    b_d   = op_b;
                    err_d = 1'b0;
`ifdef MOD_QUOTIENT_EN
                    q_d   = '0;
`endif
                    // Signed operands: negative dividend/divisor or zero divisor are rejected.
                    if (op_b == '0 || op_b[WIDTH-1] || op_a[WIDTH-1]) begin
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                alu_a  = r_q;
                alu_b  = b_q;
                alu_op = ALU_OP_SLT;
                if (alu_res[0]) begin
                    rem_d   = r_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                alu_a   = r_q;
                alu_b   = b_q;
                alu_op  = ALU_OP_SUB;
                r_d     = alu_res;
`ifdef MOD_QUOTIENT_EN
                q_d     = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
                state_d = ST_CMP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
`ifdef MOD_QUOTIENT_EN
            q_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
`ifdef MOD_QUOTIENT_EN
            q_q     <= q_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign remainder = rem_q;
`ifdef MOD_QUOTIENT_EN
    assign quotient  = q_q;
`endif

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Bench for alu_mod_sequencer with a behavioural ALU; quotient checked when MOD_QUOTIENT_EN is defined.
module tb_alu_mod_sequencer;
    import alu_mod_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done, err;
    logic [31:0] remainder, alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
`ifdef MOD_QUOTIENT_EN
    logic [31:0] quotient;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mod_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .remainder(remainder),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res)
`ifdef MOD_QUOTIENT_EN
        , .quotient(quotient)
`endif
    );

    always_comb begin
        case (alu_op)
            ALU_OP_ADD: alu_res = alu_a + alu_b;
            ALU_OP_SUB: alu_res = alu_a - alu_b;
            ALU_OP_SLT: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default:    alu_res = alu_a & alu_b;
        endcase
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rem;
        logic [31:0] quo;
        logic        err;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: plain integer division, cycle count from one SLT per pass plus one per SUB.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input string nm);
        vec_t v;
        v.a = a; v.b = b; v.name = nm;
        if (b == 0 || $signed(b) < 0 || $signed(a) < 0) begin
            v.err = 1'b1; v.rem = 0; v.quo = 0; v.lat = 1;
        end else begin
            v.err = 1'b0; v.rem = a % b; v.quo = a / b; v.lat = 2 + 2 * int'(a / b);
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int n, subs, slts;
        bit seen;
        n = 0; subs = 0; slts = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; op_a = v.a; op_b = v.b;
        while (!seen && n < 5000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            op_a  = $urandom;
            op_b  = $urandom;
            if (alu_op == ALU_OP_SUB) subs++;
            if (alu_op == ALU_OP_SLT) slts++;
            if (done) seen = 1;
        end
        if (!seen) begin
            chk({v.name, "_timeout"}, 32'(n), 32'(v.lat));
            return;
        end
        chk({v.name, "_latency"}, 32'(n), 32'(v.lat));
        chk({v.name, "_rem"}, remainder, v.rem);
        chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.err});
        chk({v.name, "_subs"}, 32'(subs), v.quo);
        chk({v.name, "_slts"}, 32'(slts), v.err ? 32'd0 : v.quo + 32'd1);
`ifdef MOD_QUOTIENT_EN
        chk({v.name, "_quo"}, quotient, v.quo);
`endif
        @(negedge clk);
        chk({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({v.name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        int n, dones;
        bit seen;
        tbl[0] = '{32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 8,  "17mod5"};
        tbl[1] = '{32'd4,  32'd7, 32'd4, 32'd0, 1'b0, 2,  "4mod7"};
        tbl[2] = '{32'd20, 32'd5, 32'd0, 32'd4, 1'b0, 10, "20mod5"};
        tbl[3] = '{32'd9,  32'd0, 32'd0, 32'd0, 1'b1, 1,  "bzero"};
        tbl[4] = '{32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0, 1'b1, 1, "aneg"};
        tbl[5] = '{32'd6,  32'd6, 32'd0, 32'd1, 1'b0, 4,  "equal"};

        reset = 1'b1; start = 1'b0; op_a = 0; op_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, {29'd0, ALU_OP_AND});
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_op(tbl[i]);

        // Extra starts while busy and on the done cycle must be ignored.
        @(negedge clk);
        start = 1'b1; op_a = 32'd17; op_b = 32'd5;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == 3);
            op_a = 32'd4; op_b = 32'd7;
            if (done) seen = 1;
        end
        chk("busy_start_latency", 32'(n), 32'd8);
        chk("busy_start_rem", remainder, 32'd2);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("done_start_no_extra_done", 32'(dones), 32'd0);

        // Reset during the SUB of 100 mod 3.
        @(negedge clk);
        start = 1'b1; op_a = 32'd100; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_sub", {29'd0, alu_op}, {29'd0, ALU_OP_SUB});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_rem", remainder, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_alu_op", {29'd0, alu_op}, {29'd0, ALU_OP_AND});
`ifdef MOD_QUOTIENT_EN
        chk("midrst_quo", quotient, 32'd0);
`endif
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("midrst_stays_idle", 32'(dones), 32'd0);
        run_op(model(32'd9, 32'd4, "9mod4"));

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 300);
            b = $urandom_range(1, 40);
            if (i % 8 == 7) b = 32'd0;
            if (i % 8 == 3) b = 32'h8000_0000 | $urandom;
            run_op(model(a, b, $sformatf("rand%0d", i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
